// File: rtl/ahb_pkg.sv
// Shared AHB bus encodings and the burst-length helper used by the arbiter.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {
    OKAY  = 2'b00,
    ERROR = 2'b01,
    RETRY = 2'b10,
    SPLIT = 2'b11
  } hresp_e;

  // Beats still to come after the NONSEQ beat of a fixed-length burst.
  function automatic logic [3:0] burst_beats(hburst_e b);
    case (b)
      WRAP4, INCR4:   return 4'd3;
      WRAP8, INCR8:   return 4'd7;
      WRAP16, INCR16: return 4'd15;
      default:        return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational masked round-robin find-first; falls back to DEF_MASTER.
module ahb_rr_picker
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int IDX_W       = 2,
  parameter int DEF_MASTER  = 0
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [NUM_MASTERS-1:0] mask,
  input  logic [IDX_W-1:0]       ptr,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [IDX_W-1:0]       idx
);

  logic [NUM_MASTERS-1:0] eligible;
  logic                   hi_found;
  logic                   lo_found;
  logic [IDX_W-1:0]       hi_idx;
  logic [IDX_W-1:0]       lo_idx;

  assign eligible = req & ~mask;

  // Descending scan so the last hit in each half is the lowest index.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        if (i > int'(ptr)) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(i);
        end else begin
          lo_found = 1'b1;
          lo_idx   = IDX_W'(i);
        end
      end
    end
  end

  always_comb begin
    if (hi_found) begin
      idx = hi_idx;
    end else if (lo_found) begin
      idx = lo_idx;
    end else begin
      idx = IDX_W'(DEF_MASTER);
    end
    grant      = '0;
    grant[idx] = 1'b1;
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// AHB multi-master arbiter: round-robin grant, burst/lock hold, bus parking.
// Optional split support is enabled with the AHB_ARB_SPLIT_EN macro.
module ahb_bus_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int HMASTER_W   = 4,
  parameter int HRESP_W     = 2,
  parameter int DEF_MASTER  = 0
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  input  logic [HRESP_W-1:0]     HRESP,
`ifdef AHB_ARB_SPLIT_EN
  input  logic [NUM_MASTERS-1:0] HSPLIT,
`endif
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [HMASTER_W-1:0]   HMASTER,
  output logic                   HMASTLOCK
);

  typedef enum logic [1:0] {ARB_IDLE, ARB_BURST, ARB_LOCKED} arb_state_e;

  localparam int                     IDX_W     = $clog2(NUM_MASTERS);
  localparam logic [IDX_W-1:0]       DEF_IDX   = IDX_W'(DEF_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEF_MASTER;

  htrans_e trans;
  hburst_e burst;
  hresp_e  resp;

  logic [NUM_MASTERS-1:0] grant;
  logic [NUM_MASTERS-1:0] win_grant;
  logic [NUM_MASTERS-1:0] split_mask;
  logic [IDX_W-1:0]       grant_idx;
  logic [IDX_W-1:0]       master;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       win_idx;
  logic                   mastlock;
  logic                   force_arb;
  logic [3:0]             beats_left;
  logic [3:0]             beats_nxt;
  arb_state_e             state;

  logic handover;
  logic lock_hold;
  logic release_pt;
  logic arb_pt;
  logic regrant;

  assign trans = htrans_e'(HTRANS);
  assign burst = hburst_e'(HBURST);
  assign resp  = hresp_e'(HRESP[1:0]);

  ahb_rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W),
    .DEF_MASTER  (DEF_MASTER)
  ) u_picker (
    .req   (HBUSREQ),
    .mask  (split_mask),
    .ptr   (rr_ptr),
    .grant (win_grant),
    .idx   (win_idx)
  );

  // While a new grant waits for its first ready edge, the old owner is only
  // finishing its address phase, so no further arbitration happens.
  always_comb begin
    handover   = (grant_idx != master);
    lock_hold  = HLOCK[master];
    release_pt = (trans == IDLE)
              || (trans == NONSEQ && burst == SINGLE)
              || (trans == SEQ && state != ARB_IDLE && beats_left == 4'd1)
              || (burst == INCR && (trans == NONSEQ || trans == SEQ) && !HBUSREQ[master]);
    arb_pt     = HREADY && (force_arb || (!handover && !lock_hold && release_pt));
    regrant    = arb_pt && (win_idx != grant_idx);
  end

  always_comb begin
    beats_nxt = beats_left;
    if (trans == NONSEQ) begin
      beats_nxt = burst_beats(burst);
    end else if (trans == SEQ && beats_left != 4'd0) begin
      beats_nxt = beats_left - 4'd1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      grant      <= DEF_GRANT;
      grant_idx  <= DEF_IDX;
      master     <= DEF_IDX;
      rr_ptr     <= DEF_IDX;
      mastlock   <= 1'b0;
      beats_left <= 4'd0;
      force_arb  <= 1'b0;
      state      <= ARB_IDLE;
    end else if (HREADY) begin
      beats_left <= beats_nxt;
      force_arb  <= 1'b0;
      master     <= grant_idx;
      mastlock   <= HLOCK[grant_idx];
      if (HLOCK[grant_idx]) begin
        state <= ARB_LOCKED;
      end else if (beats_nxt != 4'd0) begin
        state <= ARB_BURST;
      end else begin
        state <= ARB_IDLE;
      end
      if (regrant) begin
        grant     <= win_grant;
        grant_idx <= win_idx;
        rr_ptr    <= win_idx;
      end
    end else begin
      // First cycle of a two-cycle response: only the responses act here.
      case (resp)
        ERROR: begin
          beats_left <= 4'd0;
          force_arb  <= 1'b1;
          state      <= mastlock ? ARB_LOCKED : ARB_IDLE;
        end
        RETRY: begin
          beats_left <= 4'd0;
          state      <= mastlock ? ARB_LOCKED : ARB_IDLE;
        end
        SPLIT: begin
          beats_left <= 4'd0;
          state      <= mastlock ? ARB_LOCKED : ARB_IDLE;
`ifdef AHB_ARB_SPLIT_EN
          force_arb  <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

`ifdef AHB_ARB_SPLIT_EN
  logic [NUM_MASTERS-1:0] split_set;

  always_comb begin
    split_set = '0;
    if (!HREADY && resp == SPLIT && master != DEF_IDX) begin
      split_set[master] = 1'b1;
    end
  end

  // A resume pulse beats a coincident split; the parked master is never masked.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      split_mask <= '0;
    end else begin
      split_mask <= (split_mask | split_set) & ~HSPLIT & ~DEF_GRANT;
    end
  end
`else
  assign split_mask = '0;
`endif

  assign HGRANT    = grant;
  assign HMASTER   = HMASTER_W'(master);
  assign HMASTLOCK = mastlock;

endmodule
